score_feeder: RTL and testbench
===============================

// Module: score_feeder
// PURPOSE
//  Initiator side of the sequencer command interface: walks a score memory of
//  12-bit command words and hands them one at a time to the sequencer. It drives
//  a command word, waits for the sequencer's busy to rise and then fall, and only
//  then fetches the next word. It sits between a score ROM and the sequencer.
// PARAMETERS
//  ADDR_W       8        score memory address width; the score is at most 2**ADDR_W words
//  END_WORD     12'hFFF  end-of-score marker; never forwarded to the sequencer
//  LOOP         0        1: restart at address 0 after END_WORD or the last address; 0: stop
//  ACK_TIMEOUT  16       max cycles in ISSUE waiting for busy=1 before the word is skipped (>=2)
// PORTS
//  clk       in   1       system clock, rising edge
//  reset     in   1       asynchronous, active-high reset
//  start     in   1       1-cycle request to play from address 0; honoured in IDLE only
//  stop      in   1       abort playback; sampled every cycle; wins over start
//  mem_addr  out  ADDR_W  score memory read address
//  mem_data  in   12      score word; valid 1 cycle after mem_addr (synchronous ROM)
//  command   out  12      word to the sequencer; 12'h000 = no command
//  busy      in   1       sequencer busy flag
//  playing   out  1       high in every state except IDLE
//  done      out  1       1-cycle pulse when playback ends (end of score, stop, or last address with LOOP=0)
//  timeout   out  1       1-cycle pulse when a word is skipped because busy never rose
// BEHAVIOUR
//  Reset: state=IDLE, command=0, mem_addr=0, playing=0, done=0, timeout=0, timer=0.
//  All outputs are registered. The FSM has the states below.
//  - IDLE: command=0. start=1 & stop=0 -> mem_addr<=0, go to FETCH.
//  - FETCH: mem_addr is stable; go to LATCH on the next cycle.
//  - LATCH: sample mem_data.
//      - If mem_data==END_WORD: with LOOP=1 set mem_addr<=0 and go to FETCH; with LOOP=0 pulse done and go to IDLE.
//      - If mem_data==12'h000 (no-op): advance the address (see ADVANCE) without issuing it.
//      - Otherwise: command<=mem_data, timer<=0, go to ISSUE.
//  - ISSUE: command is held.
//      - If busy=1: command<=0, go to RELEASE. A busy that is already high on entry counts as acceptance.
//      - Else if timer==ACK_TIMEOUT-1: command<=0, pulse timeout, then ADVANCE.
//      - Else timer++.
//  - RELEASE: command=0. Wait for busy=0, then ADVANCE. There is no timeout here; a note may be arbitrarily long.
//  - ADVANCE rule:
//      - If mem_addr==2**ADDR_W-1: wrap to 0 and go to FETCH when LOOP=1; pulse done and go to IDLE when LOOP=0.
//      - Otherwise: mem_addr<=mem_addr+1, go to FETCH.
//  Latency from start to the first word on command is 3 cycles (IDLE->FETCH->LATCH->ISSUE).
//  Each word is presented for at least 1 cycle. A new non-zero word never appears
//  while busy=1 was last seen high in RELEASE.
//  Between any two issued words, command returns to 12'h000 for at least 1 cycle,
//  so identical consecutive words are seen as distinct.
//  stop=1 in any non-IDLE state: command<=0, go to IDLE, and pulse done. The
//  sequencer finishes its current note on its own; this block does not wait for it.
//  stop=1 in IDLE has no effect and gives no done pulse.
//  start in a non-IDLE state is ignored. With start and stop together, stop wins.
//  Asserting reset mid-note forces command=0 immediately (asynchronous clear).
//  timer is clog2(ACK_TIMEOUT) bits wide, saturating at compare and never wrapping.
// TESTING
//  1. ROM {043f,0840,0820,FFF}, LOOP=0, sequencer model busy for 5 cycles after
//     accept -> command shows 043f,000,0840,000,0820,000; done pulses once; playing
//     is then 0 and mem_addr=3.
//  2. ROM {0840,0000,0820,FFF} -> the 0000 word is never driven; command sequence is
//     0840 then 0820; mem_addr passes through 1.
//  3. busy tied 0, ROM {0840,0820,FFF}, ACK_TIMEOUT=16 -> 0840 held exactly 16
//     cycles, a timeout pulse, then 0820 held 16 cycles with a second timeout pulse,
//     then done.
//  4. LOOP=1, ROM {043f,FFF} -> 043f issued repeatedly with mem_addr cycling 0,1,0;
//     no done until stop; stop mid-RELEASE -> command=0 next cycle, done pulses,
//     state is IDLE.
//  5. Asynchronous reset while command=0840 and busy=1 -> command=0 and playing=0
//     before the next clock edge; start afterwards replays from address 0.
//  6. start held during playback and start+stop in the same cycle in IDLE -> no
//     restart, no done pulse, state remains as before.

Source files
------------

// File: rtl/score_feeder_if.sv
// Command/score-memory bundle between the score feeder, its score ROM and the sequencer.
// The master modport is the feeder's view; the slave modport is the ROM/sequencer/controller side.
interface score_feeder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_data;
  logic [11:0]       command;
  logic              busy;
  logic              playing;
  logic              done;
  logic              timeout;

  modport master (
    input  start, stop, mem_data, busy,
    output mem_addr, command, playing, done, timeout
  );

  modport slave (
    output start, stop, mem_data, busy,
    input  mem_addr, command, playing, done, timeout
  );
endinterface

// File: rtl/score_feeder.sv
// Walks a synchronous score ROM and hands each non-zero command word to the sequencer,
// waiting for busy to rise (with a skip timeout) and then fall before fetching the next word.
module score_feeder #(
  parameter int          ADDR_W      = 8,
  parameter logic [11:0] END_WORD    = 12'hFFF,
  parameter bit          LOOP        = 1'b0,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  score_feeder_if.master bus
);

  localparam int                TW         = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0]     TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       cmd_q, cmd_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              playing_q, playing_d;
  logic              advance;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    advance   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_d = '0;
        if (bus.start && !bus.stop) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (bus.mem_data == END_WORD) begin
          if (LOOP) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (bus.mem_data == 12'h000) begin
          advance = 1'b1;
        end else begin
          cmd_d   = bus.mem_data;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.busy) begin
          cmd_d   = '0;
          state_d = S_RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          cmd_d     = '0;
          timeout_d = 1'b1;
          advance   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RELEASE: begin
        cmd_d = '0;
        if (!bus.busy) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        if (LOOP) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    // An abort overrides whatever the current state decided this cycle.
    if (bus.stop && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      addr_d    = addr_q;
      cmd_d     = '0;
      done_d    = 1'b1;
      timeout_d = 1'b0;
    end

    playing_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cmd_q     <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      playing_q <= playing_d;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.command  = cmd_q;
  assign bus.playing  = playing_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_score_feeder.sv
// Directed bench for score_feeder: one LOOP=0 instance for most scenarios and one LOOP=1
// instance for looping playback, sharing a behavioural score ROM image.
module tb_score_feeder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  score_feeder_if #(.ADDR_W(8)) bus ();
  score_feeder_if #(.ADDR_W(8)) lbus ();

  score_feeder #(.ADDR_W(8), .END_WORD(12'hFFF), .LOOP(1'b0), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );
  score_feeder #(.ADDR_W(8), .END_WORD(12'hFFF), .LOOP(1'b1), .ACK_TIMEOUT(16)) u_loop (
    .clk(clk), .reset(reset), .bus(lbus.master)
  );

  // Synchronous score ROM: data valid one cycle after the address.
  logic [11:0] rom [256];
  always @(posedge clk) begin
    bus.mem_data  <= rom[bus.mem_addr];
    lbus.mem_data <= rom[lbus.mem_addr];
  end

  // Sequencer models: busy for 5 cycles after a non-zero command is seen.
  int busy_mode;  // 0: tied low, 1: sequencer model, 2: tied high
  int seq_cnt  = 0;
  int lseq_cnt = 0;
  always @(posedge clk) begin
    if (seq_cnt != 0) seq_cnt <= seq_cnt - 1;
    else if (busy_mode == 1 && bus.command != 12'h000) seq_cnt <= 5;
    if (lseq_cnt != 0) lseq_cnt <= lseq_cnt - 1;
    else if (lbus.command != 12'h000) lseq_cnt <= 5;
  end
  assign bus.busy  = (busy_mode == 2) ? 1'b1 : (busy_mode == 1) ? (seq_cnt != 0) : 1'b0;
  assign lbus.busy = (lseq_cnt != 0);

  // Monitors, sampled on the falling edge.
  logic [11:0] prev_cmd = 12'h000;
  logic [11:0] log_q [$];
  int          hold_q [$];
  int          done_cnt = 0, to_cnt = 0, ldone_cnt = 0, l_issue = 0;
  bit          saw_a1 = 1'b0, l_saw1 = 1'b0, l_wrap = 1'b0;
  logic [11:0] lprev_cmd = 12'h000;

  always @(negedge clk) begin
    if (bus.command != prev_cmd) begin
      log_q.push_back(bus.command);
      if (bus.command != 12'h000) hold_q.push_back(1);
    end else if (bus.command != 12'h000 && hold_q.size() > 0) begin
      hold_q[hold_q.size()-1] += 1;
    end
    prev_cmd = bus.command;
    if (bus.done) done_cnt++;
    if (bus.timeout) to_cnt++;
    if (bus.mem_addr == 8'd1) saw_a1 = 1'b1;
    if (lbus.done) ldone_cnt++;
    if (lbus.command == 12'h43f && lprev_cmd == 12'h000) l_issue++;
    lprev_cmd = lbus.command;
    if (lbus.mem_addr == 8'd1) l_saw1 = 1'b1;
    if (l_saw1 && lbus.mem_addr == 8'd0) l_wrap = 1'b1;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    log_q.delete();
    hold_q.delete();
    saw_a1 = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int max_cycles);
    int n = 0;
    while (done_cnt == base && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic check_log(input string tag, input int n, input logic [11:0] e [6]);
    check({tag, "_len"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(log_q[i]), 32'(e[i]));
  endtask

  task automatic load4(input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input logic [11:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  initial begin
    logic [11:0] e_t1 [6] = '{12'h43f, 12'h000, 12'h840, 12'h000, 12'h820, 12'h000};
    logic [11:0] e_t2 [6] = '{12'h840, 12'h000, 12'h820, 12'h000, 12'h000, 12'h000};
    logic [11:0] e_t5 [6] = '{12'h840, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    int base;
    int to_base;
    int n;

    for (int i = 0; i < 256; i++) rom[i] = 12'hFFF;
    busy_mode  = 1;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    lbus.start = 1'b0;
    lbus.stop  = 1'b0;
    #2;
    check("rst_command", 32'(bus.command), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_playing", 32'(bus.playing), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    step(2);
    reset = 1'b0;
    step(2);

    // 1: basic playback with the sequencer model
    load4(12'h43f, 12'h840, 12'h820, 12'hFFF);
    clear_logs();
    base = done_cnt;
    pulse_start();
    check("t1_playing", 32'(bus.playing), 32'h1);
    step();
    check("t1_cmd_latch", 32'(bus.command), 32'h0);
    step();
    check("t1_latency", 32'(bus.command), 32'h43f);
    wait_done("t1", base, 300);
    step(5);
    check_log("t1", 6, e_t1);
    check("t1_done_count", 32'(done_cnt - base), 32'd1);
    check("t1_playing_end", 32'(bus.playing), 32'h0);
    check("t1_mem_addr", 32'(bus.mem_addr), 32'd3);

    // 2: no-op word is skipped
    load4(12'h840, 12'h000, 12'h820, 12'hFFF);
    clear_logs();
    base = done_cnt;
    pulse_start();
    wait_done("t2", base, 300);
    step(3);
    check_log("t2", 4, e_t2);
    check("t2_saw_addr1", 32'(saw_a1), 32'h1);
    check("t2_mem_addr", 32'(bus.mem_addr), 32'd3);

    // 3: busy never rises -> each word held ACK_TIMEOUT cycles then skipped
    busy_mode = 0;
    load4(12'h840, 12'h820, 12'hFFF, 12'hFFF);
    clear_logs();
    base    = done_cnt;
    to_base = to_cnt;
    pulse_start();
    wait_done("t3", base, 300);
    step(3);
    check_log("t3", 4, e_t2);
    check("t3_holds", 32'(hold_q.size()), 32'd2);
    for (int i = 0; i < hold_q.size() && i < 2; i++)
      check($sformatf("t3_hold%0d", i), 32'(hold_q[i]), 32'd16);
    check("t3_timeouts", 32'(to_cnt - to_base), 32'd2);
    check("t3_done_count", 32'(done_cnt - base), 32'd1);
    check("t3_mem_addr", 32'(bus.mem_addr), 32'd2);
    busy_mode = 1;

    // 4: looping playback, then stop during RELEASE
    load4(12'h43f, 12'hFFF, 12'hFFF, 12'hFFF);
    lbus.start = 1'b1;
    step();
    lbus.start = 1'b0;
    step(60);
    check("t4_issues", 32'(l_issue >= 3), 32'h1);
    check("t4_addr_wrap", 32'(l_wrap), 32'h1);
    check("t4_no_done", 32'(ldone_cnt), 32'd0);
    check("t4_playing", 32'(lbus.playing), 32'h1);
    n = 0;
    while (!(lbus.busy && lbus.command == 12'h000 && lbus.playing) && n < 40) begin
      step();
      n++;
    end
    check("t4_in_release", 32'(lbus.busy && lbus.command == 12'h000), 32'h1);
    lbus.stop = 1'b1;
    step();
    lbus.stop = 1'b0;
    check("t4_stop_cmd", 32'(lbus.command), 32'h0);
    check("t4_stop_done", 32'(lbus.done), 32'h1);
    check("t4_stop_idle", 32'(lbus.playing), 32'h0);
    step(3);
    check("t4_done_once", 32'(ldone_cnt), 32'd1);
    check("t4_still_idle", 32'(lbus.playing), 32'h0);

    // 5: asynchronous reset mid-note, then replay from address 0
    busy_mode = 2;
    load4(12'h840, 12'hFFF, 12'hFFF, 12'hFFF);
    pulse_start();
    n = 0;
    while (bus.command != 12'h840 && n < 20) begin
      step();
      n++;
    end
    check("t5_cmd_before", 32'(bus.command), 32'h840);
    #1 reset = 1'b1;
    #1;
    check("t5_async_cmd", 32'(bus.command), 32'h0);
    check("t5_async_playing", 32'(bus.playing), 32'h0);
    step();
    reset     = 1'b0;
    busy_mode = 1;
    check("t5_addr_after_rst", 32'(bus.mem_addr), 32'd0);
    step();
    clear_logs();
    base = done_cnt;
    pulse_start();
    wait_done("t5", base, 300);
    step(3);
    check_log("t5", 2, e_t5);
    check("t5_mem_addr", 32'(bus.mem_addr), 32'd1);

    // 6: start+stop in IDLE does nothing; start held during playback is ignored
    load4(12'h43f, 12'h840, 12'h820, 12'hFFF);
    base      = done_cnt;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("t6_ss_playing", 32'(bus.playing), 32'h0);
    step(2);
    check("t6_ss_no_done", 32'(done_cnt - base), 32'd0);
    check("t6_ss_addr", 32'(bus.mem_addr), 32'd1);
    clear_logs();
    bus.start = 1'b1;
    step(8);
    bus.start = 1'b0;
    wait_done("t6", base, 300);
    step(5);
    check_log("t6", 6, e_t1);
    check("t6_done_count", 32'(done_cnt - base), 32'd1);
    check("t6_mem_addr", 32'(bus.mem_addr), 32'd3);
    check("t6_playing_end", 32'(bus.playing), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
